// File: rtl/fire8_squeeze_buf_if.sv
// Handshake/bus bundle between the fire8 squeeze stage, this buffer and the
// fire8 expand stage. The buffer attaches through the slave modport.
interface fire8_squeeze_buf_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DSP_NO = 112
);
  logic                             sq_sample;
  logic [0:DSP_NO-1][WIDTH-1:0]     sq_ofm;
  logic                             rd_en;
  logic [WIDTH-1:0]                 dout;
  logic                             dout_valid;
  logic                             buf_ready;
  logic                             rd_done;
  logic                             ram_feedback;
  logic                             overrun;

  // Producer/consumer side (squeeze + expand stages)
  modport master (
    output sq_sample, sq_ofm, rd_en,
    input  dout, dout_valid, buf_ready, rd_done, ram_feedback, overrun
  );

  // Buffer side
  modport slave (
    input  sq_sample, sq_ofm, rd_en,
    output dout, dout_valid, buf_ready, rd_done, ram_feedback, overrun
  );
endinterface

// File: rtl/fire8_squeeze_buf.sv
// fire8_squeeze_buf: captures each parallel squeeze output vector, serialises
// it into a single-port store until WOUT*WOUT pixels are held, then streams the
// map channel-serially (pixel-major) to the expand stage.
// Optional macro BUF_RELU_CLAMP_EN: words with the sign bit set are stored as 0.
module fire8_squeeze_buf #(
  parameter int unsigned WOUT   = 8,
  parameter int unsigned DSP_NO = 112,
  parameter int unsigned WIDTH  = 16
) (
  input logic                clk,
  input logic                rst,
  fire8_squeeze_buf_if.slave bus
);

  localparam int unsigned NPIX  = WOUT * WOUT;
  localparam int unsigned DEPTH = NPIX * DSP_NO;
  localparam int unsigned AW    = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;
  localparam int unsigned CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int unsigned PW    = $clog2(NPIX + 1);

  typedef enum logic [1:0] {FILL, SER, FULL, DRAIN} state_t;

  state_t                       state;
  logic [PW-1:0]                pix;
  logic [CW-1:0]                ch;
  logic [AW-1:0]                rd_ptr;
  logic [0:DSP_NO-1][WIDTH-1:0] shadow;
  logic [WIDTH-1:0]             mem [DEPTH];
  logic [WIDTH-1:0]             rd_q;
  logic                         out_live;

  logic                         mem_we;
  logic                         mem_re;
  logic [AW-1:0]                mem_addr;
  logic [WIDTH-1:0]             wr_word;
  logic                         last_ch;
  logic                         last_pix;
  logic                         last_issue;

  assign last_ch  = (ch == CW'(DSP_NO - 1));
  assign last_pix = (pix == PW'(NPIX - 1));

  // Single-port access control: writes only while serialising, reads only while streaming
  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
`ifdef BUF_RELU_CLAMP_EN
    wr_word    = shadow[ch][WIDTH-1] ? '0 : shadow[ch];
`else
    wr_word    = shadow[ch];
`endif
    case (state)
      SER: begin
        mem_we   = 1'b1;
        mem_addr = AW'(32'(pix) * DSP_NO + 32'(ch));
      end
      FULL: begin
        mem_re   = bus.rd_en;
        mem_addr = '0;
      end
      DRAIN: begin
        mem_re   = bus.rd_en;
        mem_addr = rd_ptr;
      end
      default: ;
    endcase
    last_issue = mem_re && (mem_addr == AW'(DEPTH - 1));
  end

  // Storage array with registered read; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= wr_word;
    if (mem_re) rd_q <= mem[mem_addr];
  end

  // Shadow bank: only a sample accepted in FILL may overwrite it
  always_ff @(posedge clk) begin
    if (state == FILL && bus.sq_sample) shadow <= bus.sq_ofm;
  end

  // Control FSM, counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= FILL;
      pix              <= '0;
      ch               <= '0;
      rd_ptr           <= '0;
      out_live         <= 1'b0;
      bus.dout_valid   <= 1'b0;
      bus.buf_ready    <= 1'b0;
      bus.rd_done      <= 1'b0;
      bus.ram_feedback <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.dout_valid   <= mem_re;
      bus.rd_done      <= last_issue;
      bus.ram_feedback <= 1'b0;
      if (mem_re) out_live <= 1'b1;
      if (bus.sq_sample && state != FILL) bus.overrun <= 1'b1;

      case (state)
        FILL: begin
          if (bus.sq_sample) begin
            state <= SER;
            ch    <= '0;
          end
        end
        SER: begin
          if (last_ch) begin
            ch  <= '0;
            pix <= pix + PW'(1);
            if (last_pix) begin
              state            <= FULL;
              bus.buf_ready    <= 1'b1;
              bus.ram_feedback <= 1'b1;
            end else begin
              state <= FILL;
            end
          end else begin
            ch <= ch + CW'(1);
          end
        end
        FULL, DRAIN: begin
          if (mem_re) begin
            if (last_issue) begin
              state         <= FILL;
              rd_ptr        <= '0;
              pix           <= '0;
              ch            <= '0;
              bus.buf_ready <= 1'b0;
            end else begin
              state  <= DRAIN;
              rd_ptr <= mem_addr + AW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Output word is forced to 0 until the first read after reset, then holds between reads
  assign bus.dout = out_live ? rd_q : '0;

endmodule
